// File: rtl/rate_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rate_decoder : recovers the Speed code of a rate-divided counter stream  |
// | Optional macro STEP_CHECK_EN adds the +1 step checker.     Rev 1.0       |
// +--------------------------------------------------------------------------+
module rate_decoder #(
  parameter int PERIOD1 = 500,
  parameter int PERIOD2 = 1000,
  parameter int PERIOD3 = 2000,
  parameter int TOL     = 2,
  parameter int CNT_W   = 12
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic [3:0] CounterValue,
  output logic [1:0] Speed,
  output logic       Valid,
  output logic       Lost,
  output logic       StepError
);

  localparam int LW = CNT_W + 1;

  localparam logic [LW-1:0]    c_ONE        = LW'(1);
  localparam logic [LW-1:0]    c_P1_LO      = LW'(PERIOD1 - TOL);
  localparam logic [LW-1:0]    c_P1_HI      = LW'(PERIOD1 + TOL);
  localparam logic [LW-1:0]    c_P2_LO      = LW'(PERIOD2 - TOL);
  localparam logic [LW-1:0]    c_P2_HI      = LW'(PERIOD2 + TOL);
  localparam logic [LW-1:0]    c_P3_LO      = LW'(PERIOD3 - TOL);
  localparam logic [LW-1:0]    c_P3_HI      = LW'(PERIOD3 + TOL);
  // Timeout fires on the edge where the counter would become PERIOD3+TOL+1.
  localparam logic [CNT_W-1:0] c_TIMEOUT_M1 = CNT_W'(PERIOD3 + TOL);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ACQ     = 2'd1;
  localparam logic [1:0] c_CONFIRM = 2'd2;
  localparam logic [1:0] c_LOCKED  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       prev_q;
  logic [1:0]       cand_q, cand_d;
  logic [1:0]       speed_q, speed_d;
  logic             lost_q;

  logic             w_change;
  logic [LW-1:0]    w_len;
  logic             w_match;
  logic [1:0]       w_code;
  logic             w_timeout;

  assign w_change  = (CounterValue != prev_q);
  assign w_len     = {1'b0, cnt_q} + c_ONE;
  assign cnt_d     = w_change ? '0 : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
  assign w_timeout = (state_q != c_IDLE) && !w_change && (cnt_q == c_TIMEOUT_M1);

  always_comb begin
    w_match = 1'b1;
    w_code  = 2'b00;
    if (w_len == c_ONE) begin
      w_code = 2'b00;
    end else if (w_len >= c_P1_LO && w_len <= c_P1_HI) begin
      w_code = 2'b01;
    end else if (w_len >= c_P2_LO && w_len <= c_P2_HI) begin
      w_code = 2'b10;
    end else if (w_len >= c_P3_LO && w_len <= c_P3_HI) begin
      w_code = 2'b11;
    end else begin
      w_match = 1'b0;
    end
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
      prev_q  <= CounterValue;
      cand_q  <= 2'b00;
      speed_q <= 2'b00;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= CounterValue;
      cand_q  <= cand_d;
      speed_q <= speed_d;
      lost_q  <= w_timeout;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    speed_d = speed_q;
    if (w_change) begin
      case (state_q)
        c_IDLE: state_d = c_ACQ;
        c_ACQ: begin
          if (w_match) begin
            cand_d  = w_code;
            state_d = c_CONFIRM;
          end
        end
        c_CONFIRM: begin
          if (!w_match) begin
            state_d = c_ACQ;
          end else if (w_code == cand_q) begin
            state_d = c_LOCKED;
            speed_d = cand_q;
          end else begin
            cand_d = w_code;
          end
        end
        c_LOCKED: begin
          if (!w_match) begin
            state_d = c_ACQ;
          end else if (w_code != speed_q) begin
            cand_d  = w_code;
            state_d = c_CONFIRM;
          end
        end
        default: state_d = c_IDLE;
      endcase
    end else if (w_timeout) begin
      state_d = c_IDLE;
    end
  end

  always_comb begin
    Speed = speed_q;
    Valid = (state_q == c_LOCKED);
    Lost  = lost_q;
  end

`ifdef STEP_CHECK_EN
  logic step_q;
  logic w_step_bad;

  // 4-bit add wraps, so 15->0 counts as a legal step.
  assign w_step_bad = w_change && (state_q == c_LOCKED) &&
                      (CounterValue != prev_q + 4'd1);

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= w_step_bad;
    end
  end

  assign StepError = step_q;
`else
  assign StepError = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rate_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rate_decoder : directed self-checking bench for rate_decoder          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rate_decoder;

`ifdef STEP_CHECK_EN
  localparam logic c_STEP_EXP = 1'b1;
`else
  localparam logic c_STEP_EXP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] cv;
  logic [1:0] speed;
  logic       valid;
  logic       lost;
  logic       step_err;

  int n_checks = 0;
  int n_pass   = 0;

  rate_decoder dut (
    .ClockIn     (clk),
    .Reset       (rst),
    .CounterValue(cv),
    .Speed       (speed),
    .Valid       (valid),
    .Lost        (lost),
    .StepError   (step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // New value is applied so that the next edge is the change edge.
  task automatic chg(input logic [3:0] v);
    cv = v;
    tick();
  endtask

  // Change edge lands exactly n edges after the previous change edge.
  task automatic gap(input int n, input logic [3:0] v);
    hold(n - 1);
    chg(v);
  endtask

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] e_speed, input logic e_valid,
                         input logic e_lost, input logic e_step);
    chk({tag, ".Speed"},     speed,           e_speed);
    chk({tag, ".Valid"},     {1'b0, valid},    {1'b0, e_valid});
    chk({tag, ".Lost"},      {1'b0, lost},     {1'b0, e_lost});
    chk({tag, ".StepError"}, {1'b0, step_err}, {1'b0, e_step});
  endtask

  initial begin
    rst = 1'b1;
    cv  = 4'd0;
    hold(2);
    chk_out("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Speed 01: lock visible just after the third change edge.
    chg(4'd1);
    chk_out("s01_c1", 2'b00, 1'b0, 1'b0, 1'b0);
    gap(500, 4'd2);
    chk_out("s01_c2", 2'b00, 1'b0, 1'b0, 1'b0);
    hold(499);
    chk_out("s01_pre", 2'b00, 1'b0, 1'b0, 1'b0);
    chg(4'd3);
    chk_out("s01_lock", 2'b01, 1'b1, 1'b0, 1'b0);
    gap(500, 4'd4);
    gap(500, 4'd5);
    chk_out("s01_hold", 2'b01, 1'b1, 1'b0, 1'b0);

    // Illegal jump 5->9 on a good interval.
    gap(500, 4'd9);
    chk_out("jump", 2'b01, 1'b1, 1'b0, c_STEP_EXP);
    tick();
    chk_out("jump_end", 2'b01, 1'b1, 1'b0, 1'b0);
    hold(498);
    chg(4'd10);
    chk_out("after_jump", 2'b01, 1'b1, 1'b0, 1'b0);

    // Timeout from LOCKED: Lost 2003 edges after the last change.
    hold(2002);
    chk_out("pre_timeout", 2'b01, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("timeout", 2'b01, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("post_timeout", 2'b01, 1'b0, 1'b0, 1'b0);

    // Speed 00 from IDLE, including the 15->0 wrap.
    chg(4'd11);
    chk_out("s00_c1", 2'b01, 1'b0, 1'b0, 1'b0);
    chg(4'd12);
    chk_out("s00_c2", 2'b01, 1'b0, 1'b0, 1'b0);
    chg(4'd13);
    chk_out("s00_lock", 2'b00, 1'b1, 1'b0, 1'b0);
    chg(4'd14);
    chg(4'd15);
    chg(4'd0);
    chk_out("wrap", 2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("wrap_next", 2'b00, 1'b1, 1'b0, 1'b0);

    // Switch to 1000-cycle steps, then to 2000-cycle steps.
    hold(998);
    chg(4'd1);
    chk_out("to10_drop", 2'b00, 1'b0, 1'b0, 1'b0);
    gap(1000, 4'd2);
    chk_out("s10_lock", 2'b10, 1'b1, 1'b0, 1'b0);
    gap(1000, 4'd3);
    chk_out("s10_hold", 2'b10, 1'b1, 1'b0, 1'b0);
    gap(2000, 4'd4);
    chk_out("to11_drop", 2'b10, 1'b0, 1'b0, 1'b0);
    gap(2000, 4'd5);
    chk_out("s11_lock", 2'b11, 1'b1, 1'b0, 1'b0);

    // Reset asserted while locked.
    rst = 1'b1;
    tick();
    chk_out("mid_reset", 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Tolerance edges: 497/503 never match, 498/502 lock Speed 01.
    chg(4'd6);
    gap(497, 4'd7);
    chk_out("tol_497a", 2'b00, 1'b0, 1'b0, 1'b0);
    gap(503, 4'd8);
    chk_out("tol_503a", 2'b00, 1'b0, 1'b0, 1'b0);
    gap(497, 4'd9);
    chk_out("tol_497b", 2'b00, 1'b0, 1'b0, 1'b0);
    gap(503, 4'd10);
    chk_out("tol_503b", 2'b00, 1'b0, 1'b0, 1'b0);
    gap(498, 4'd11);
    chk_out("tol_498", 2'b00, 1'b0, 1'b0, 1'b0);
    gap(502, 4'd12);
    chk_out("tol_502_lock", 2'b01, 1'b1, 1'b0, 1'b0);

    // Unmatched interval while locked drops back to ACQ, then relocks.
    gap(700, 4'd13);
    chk_out("unmatched", 2'b01, 1'b0, 1'b0, 1'b0);
    gap(500, 4'd14);
    chk_out("reacq", 2'b01, 1'b0, 1'b0, 1'b0);
    gap(500, 4'd15);
    chk_out("relock", 2'b01, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
